// File: rtl/pwm_sample_loader_pkg.sv
// Shared constants and FSM encoding for the PWM sample loader and pwm_gen.
package pwm_pkg;
  localparam int P_NO_CHANNELS    = 16;
  localparam int P_PWM_RESOLUTION = 16;
  localparam int P_CH_IDX_W       = 4;
  localparam int P_ON_VEC_W       = P_NO_CHANNELS * P_PWM_RESOLUTION;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } ldr_state_e;

  typedef logic [P_PWM_RESOLUTION-1:0] level_t;
endpackage

// File: rtl/pwm_sample_loader_if.sv
// Target-write handshake between the control path (master) and the loader (slave).
interface pwm_sample_loader_if;
  logic                             wr_valid_ih;
  logic                             wr_ready_oh;
  logic [pwm_pkg::P_CH_IDX_W-1:0]   wr_chan_id;
  logic [pwm_pkg::P_PWM_RESOLUTION-1:0] wr_data_id;

  modport master (output wr_valid_ih, output wr_chan_id, output wr_data_id, input wr_ready_oh);
  modport slave  (input wr_valid_ih, input wr_chan_id, input wr_data_id, output wr_ready_oh);
endinterface

// File: rtl/pwm_sample_loader_ramp_calc.sv
// Combinational slew limiter: moves active toward target by at most step (0 = jump).
module pwm_ramp_calc
  import pwm_pkg::*;
(
  input  level_t active_id,
  input  level_t target_id,
  input  level_t step_id,
  output level_t level_od
);
  always_comb begin
    level_od = target_id;
    if (step_id != '0) begin
      if (target_id > active_id) begin
        if ((target_id - active_id) > step_id) level_od = active_id + step_id;
      end else if (active_id > target_id) begin
        if ((active_id - target_id) > step_id) level_od = active_id - step_id;
      end
    end
  end
endmodule

// File: rtl/pwm_sample_loader.sv
// Per-channel target/stage/active store feeding pwm_gen; commits on refresh only.
// Optional ramp_busy_oh status output when PWM_LOADER_STATUS_EN is defined.
module pwm_sample_loader
  import pwm_pkg::*;
(
  input  logic                  clk_ir,
  input  logic                  rst_il,
  input  logic                  pwm_en_ih,
  pwm_sample_loader_if.slave    wr_if,
  input  level_t                ramp_step_id,
  input  logic                  pwm_refresh_ih,
  output logic [P_ON_VEC_W-1:0] pwm_on_vec_od
`ifdef PWM_LOADER_STATUS_EN
  ,
  output logic                  ramp_busy_oh
`endif
);
  ldr_state_e            state_q, state_d;
  logic [P_CH_IDX_W-1:0] chan_idx_q, chan_idx_d;
  level_t                target_q [P_NO_CHANNELS];
  level_t                target_d [P_NO_CHANNELS];
  level_t                active_q [P_NO_CHANNELS];
  level_t                active_d [P_NO_CHANNELS];
  level_t                stage_q  [P_NO_CHANNELS];
  level_t                stage_d  [P_NO_CHANNELS];
  logic                  wr_ready_q, wr_ready_d;
  level_t                ramp_level;
`ifdef PWM_LOADER_STATUS_EN
  logic                  busy_q, busy_d;
`endif

  pwm_ramp_calc u_ramp (
    .active_id (active_q[chan_idx_q]),
    .target_id (target_q[chan_idx_q]),
    .step_id   (ramp_step_id),
    .level_od  (ramp_level)
  );

  always_comb begin
    state_d    = state_q;
    chan_idx_d = chan_idx_q;
    target_d   = target_q;
    active_d   = active_q;
    stage_d    = stage_q;
`ifdef PWM_LOADER_STATUS_EN
    busy_d     = busy_q;
`endif
    if (wr_if.wr_valid_ih && wr_ready_q) target_d[wr_if.wr_chan_id] = wr_if.wr_data_id;

    // Disable overrides everything, including a coincident refresh.
    if (!pwm_en_ih) begin
      state_d    = IDLE;
      chan_idx_d = '0;
      active_d   = '{default: '0};
      stage_d    = '{default: '0};
`ifdef PWM_LOADER_STATUS_EN
      busy_d     = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_d    = CALC;
          chan_idx_d = '0;
        end
        CALC: begin
          stage_d[chan_idx_q] = ramp_level;
          chan_idx_d          = chan_idx_q + P_CH_IDX_W'(1);
          if (chan_idx_q == P_CH_IDX_W'(P_NO_CHANNELS - 1)) begin
            state_d = HOLD;
`ifdef PWM_LOADER_STATUS_EN
            busy_d = 1'b0;
            for (int i = 0; i < P_NO_CHANNELS; i++)
              if (stage_d[i] != target_q[i]) busy_d = 1'b1;
`endif
          end
        end
        HOLD: begin
          if (pwm_refresh_ih) begin
            active_d = stage_q;
            state_d  = CALC;
          end
        end
        default: begin
          state_d    = IDLE;
          chan_idx_d = '0;
        end
      endcase
    end
    wr_ready_d = (state_d != CALC);
  end

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      state_q    <= IDLE;
      chan_idx_q <= '0;
      target_q   <= '{default: '0};
      active_q   <= '{default: '0};
      stage_q    <= '{default: '0};
      wr_ready_q <= 1'b1;
`ifdef PWM_LOADER_STATUS_EN
      busy_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      chan_idx_q <= chan_idx_d;
      target_q   <= target_d;
      active_q   <= active_d;
      stage_q    <= stage_d;
      wr_ready_q <= wr_ready_d;
`ifdef PWM_LOADER_STATUS_EN
      busy_q     <= busy_d;
`endif
    end
  end

  always_comb begin
    pwm_on_vec_od = '0;
    for (int i = 0; i < P_NO_CHANNELS; i++)
      pwm_on_vec_od[i*P_PWM_RESOLUTION +: P_PWM_RESOLUTION] = active_q[i];
  end

  assign wr_if.wr_ready_oh = wr_ready_q;
`ifdef PWM_LOADER_STATUS_EN
  assign ramp_busy_oh = busy_q;
`endif
endmodule
